fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Parametrised fetch-stage controller for the pipelined processor. Drives PC write/select and IR1 load, and adds what the single-cycle decoder lacked: a state machine with decode-stall handling, instruction-memory wait handling, and multi-cycle branch-shadow flushing. It also supports a resumable STOP halt that a late taken branch can override, plus a fetched-instruction counter. Sits between the PC/instruction memory and IR1, taking `branch` from the execute stage and `stall` from decode hazard logic.

## Interface
- `OPCODE_W`, 4: opcode field width.
- `STOP_OP`, 1: opcode that halts fetch.
- `FLUSH_SLOTS`, 1: bubbles inserted into IR1 after a taken branch (1..15).
- `CNT_W`, 16: width of `fetch_count`.

- `clock`  in  1: sole clock, rising edge.
- `resetn`  in  1: reset, synchronous, active-low.
- `opcode`  in  OPCODE_W: opcode currently in IR1.
- `branch`  in  1: taken branch from execute; select target PC.
- `stall`  in  1: decode hazard; hold PC and IR1.
- `mem_ready`  in  1: instruction memory word valid this cycle.
- `resume`  in  1: leave HALT.
- `pc_write`  out  1: PC register write enable.
- `pc_sel`  out  1: 0 = PC+1, 1 = branch target.
- `ir1_load`  out  1: IR1 write enable.
- `ir1_flush`  out  1: IR1 loads NOP instead of memory word (valid only with `ir1_load`).
- `halted`  out  1: registered; high in HALT.
- `fetch_count`  out  CNT_W: registered count of real instructions loaded into IR1.

## Operation
- States: `IDLE`, `RUN`, `FLUSH`, `HALT`. State register 2 bits, flush counter 4 bits.
- All control outputs are Mealy, combinational from state and inputs. Default value is 0.
- `IDLE`: outputs 0. Always goes to `RUN` next cycle.
- `RUN` priority, highest first:
  1. `branch`: `pc_sel=1, pc_write=1, ir1_load=1, ir1_flush=1`. Go to `FLUSH` with count `FLUSH_SLOTS-1` if `FLUSH_SLOTS>1`, else stay in `RUN`.
  2. `stall`: all outputs 0. Stay in `RUN`.
  3. `opcode==STOP_OP`: all outputs 0. Go to `HALT`.
  4. `!mem_ready`: `ir1_load=1, ir1_flush=1, pc_write=0`. Stay in `RUN`.
  5. Otherwise: `pc_write=1, pc_sel=0, ir1_load=1, ir1_flush=0`.
- `FLUSH`:
  - `ir1_load=1, ir1_flush=1`. PC not written unless `branch`.
  - Decrement the count. Return to `RUN` when the count reaches 0.
  - A new `branch` in `FLUSH` restarts the flush exactly as in `RUN` case 1.
  - `stall` is ignored in `FLUSH`, because bubbles are always safe.
- `HALT`:
  - Outputs 0.
  - `branch` is handled as in `RUN` case 1: the STOP was wrong-path.
  - `resume` with no `branch`: go to `RUN`, with no output change that cycle.
  - `branch` takes priority over `resume`.
- `fetch_count` increments on every cycle with `ir1_load & !ir1_flush`. It wraps modulo 2^CNT_W.

## Timing
- Synchronous reset when `resetn=0` at a clock edge:
  - state ← `IDLE`, flush count ← 0, `halted` ← 0, `fetch_count` ← 0.
  - Combinational outputs are 0 while reset is asserted.
- First real fetch is on the 2nd clock edge after `resetn` rises (one `IDLE` cycle).
- Branch redirect takes effect at the same edge `branch` is sampled. Exactly `FLUSH_SLOTS` bubble cycles are written, including the branch cycle.
- `halted` rises one cycle after STOP is seen. It falls one cycle after a resume or branch exit.
- Reset mid-`FLUSH` or mid-`HALT` abandons all state. No pending flush survives reset.
- `stall` and `!mem_ready` together: `stall` wins, and nothing is written.

## Structure
- A shared package `cpu_pkg` holds:
  - the opcode constants (LOAD=0, STOP=1, STORE=2, ADD=4, BZ=5, SUB=6, NAND=8, BNZ=9, NOP=10, BPZ=13; SHIFT=3 and ORI=7 on 3-bit field);
  - the `fetch_state_t` encoding.
- `STOP_OP` defaults to the package constant.
- Single module, no sub-module. The flush counter is inline.

## Test plan
- Reset release, `mem_ready=1`, opcode ADD: cycle 0 all outputs 0. From cycle 1, `pc_write=ir1_load=1, pc_sel=0`. `fetch_count` reads 5 after 5 RUN cycles.
- `FLUSH_SLOTS=3`, `branch` pulsed 1 cycle in RUN: cycle t has `pc_sel=1, pc_write=1, ir1_flush=1`. Cycles t+1 and t+2 have `ir1_flush=1, pc_write=0`. Normal fetch resumes at t+3, and `fetch_count` is unchanged over t..t+2.
- opcode=1 (STOP): outputs 0 that cycle and `halted=1` next. Hold 10 cycles with no writes. `resume` → `halted=0` next cycle, then fetch resumes.
- In HALT, `branch` and `resume` together: branch redirect (`pc_sel=1`), then `FLUSH_SLOTS` bubbles, then RUN.
- `stall=1` with `mem_ready=0` for 3 cycles: all outputs 0. Then `stall=0, mem_ready=0`: bubble with `ir1_flush=1, pc_write=0`.
- `resetn=0` during FLUSH with count 2: state `IDLE` next edge and `fetch_count=0`. No residual bubbles after the `IDLE` cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcode map and fetch-stage state encoding.
package cpu_pkg;

    localparam int unsigned OP_LOAD  = 0;
    localparam int unsigned OP_STOP  = 1;
    localparam int unsigned OP_STORE = 2;
    localparam int unsigned OP_ADD   = 4;
    localparam int unsigned OP_BZ    = 5;
    localparam int unsigned OP_SUB   = 6;
    localparam int unsigned OP_NAND  = 8;
    localparam int unsigned OP_BNZ   = 9;
    localparam int unsigned OP_NOP   = 10;
    localparam int unsigned OP_BPZ   = 13;
    // SHIFT and ORI are encoded on the short 3-bit opcode field
    localparam int unsigned OP_SHIFT = 3;
    localparam int unsigned OP_ORI   = 7;

    localparam int unsigned FETCH_STATE_W = 2;
    localparam int unsigned FLUSH_CNT_W   = 4;

    typedef logic [FETCH_STATE_W-1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_RUN   = 2'd1;
    localparam fetch_state_t ST_FLUSH = 2'd2;
    localparam fetch_state_t ST_HALT  = 2'd3;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: PC/IR1 write control with stall, memory-wait,
// branch-shadow flush and resumable STOP halt; counts real fetched instructions.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned STOP_OP     = OP_STOP,
    parameter int unsigned FLUSH_SLOTS = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                branch,
    input  logic                stall,
    input  logic                mem_ready,
    input  logic                resume,
    output logic                pc_write,
    output logic                pc_sel,
    output logic                ir1_load,
    output logic                ir1_flush,
    output logic                halted,
    output logic [CNT_W-1:0]    fetch_count
);

    fetch_state_t           state, state_nxt;
    logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
    logic                   redirect;

    // Next-state and Mealy outputs; everything held at 0 while in reset
    always_comb begin
        pc_write      = 1'b0;
        pc_sel        = 1'b0;
        ir1_load      = 1'b0;
        ir1_flush     = 1'b0;
        redirect      = 1'b0;
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;

        if (resetn) begin
            case (state)
                ST_IDLE: state_nxt = ST_RUN;
                ST_RUN: begin
                    if (branch) begin
                        redirect = 1'b1;
                    end else if (stall) begin
                        state_nxt = ST_RUN;
                    end else if (opcode == OPCODE_W'(STOP_OP)) begin
                        state_nxt = ST_HALT;
                    end else if (!mem_ready) begin
                        ir1_load  = 1'b1;
                        ir1_flush = 1'b1;
                    end else begin
                        pc_write = 1'b1;
                        ir1_load = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    ir1_load  = 1'b1;
                    ir1_flush = 1'b1;
                    if (branch) begin
                        redirect = 1'b1;
                    end else if (flush_cnt <= FLUSH_CNT_W'(1)) begin
                        flush_cnt_nxt = '0;
                        state_nxt     = ST_RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
                    end
                end
                ST_HALT: begin
                    if (branch) begin
                        redirect = 1'b1;
                    end else if (resume) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase

            // Taken branch: redirect PC now, the branch cycle is the first bubble
            if (redirect) begin
                pc_sel    = 1'b1;
                pc_write  = 1'b1;
                ir1_load  = 1'b1;
                ir1_flush = 1'b1;
                if (FLUSH_SLOTS > 1) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_SLOTS - 1);
                end else begin
                    state_nxt     = ST_RUN;
                    flush_cnt_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            flush_cnt   <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            halted    <= (state_nxt == ST_HALT);
            if (ir1_load && !ir1_flush) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a three-slot branch shadow.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [3:0]       ctl;   // {pc_write, pc_sel, ir1_load, ir1_flush}
        logic             halt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clock = 1'b0;
    logic             resetn;
    logic [3:0]       opcode;
    logic             branch, stall, mem_ready, resume;
    logic             pc_write, pc_sel, ir1_load, ir1_flush, halted;
    logic [CNT_W-1:0] fetch_count;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_cnt;
    int               n_tests = 0;
    int               n_fail  = 0;

    localparam logic [3:0] ADD  = 4'(OP_ADD);
    localparam logic [3:0] STOP = 4'(OP_STOP);
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] FET  = 4'b1010;
    localparam logic [3:0] BRN  = 4'b1111;
    localparam logic [3:0] BUB  = 4'b0011;

    fetch_ctrl #(.FLUSH_SLOTS(3), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetn(resetn), .opcode(opcode), .branch(branch),
        .stall(stall), .mem_ready(mem_ready), .resume(resume),
        .pc_write(pc_write), .pc_sel(pc_sel), .ir1_load(ir1_load),
        .ir1_flush(ir1_flush), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pop one expectation per cycle, sampled mid-cycle
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("ctl", 32'({pc_write, pc_sel, ir1_load, ir1_flush}), 32'(e.ctl));
            check("halted", 32'(halted), 32'(e.halt));
            check("fetch_count", 32'(fetch_count), 32'(e.cnt));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it
    task automatic cyc(input logic rn, input logic br, input logic st, input logic mr,
                       input logic rs, input logic [3:0] op,
                       input logic [3:0] ctl, input logic hlt);
        exp_t e;
        resetn = rn; branch = br; stall = st; mem_ready = mr; resume = rs; opcode = op;
        e.ctl = ctl; e.halt = hlt; e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (!rn) exp_cnt = '0;
        else if (ctl[1] && !ctl[0]) exp_cnt = exp_cnt + CNT_W'(1);
    endtask

    initial begin
        resetn = 1'b0; branch = 1'b0; stall = 1'b0; mem_ready = 1'b1;
        resume = 1'b0; opcode = ADD; exp_cnt = '0;
        repeat (2) @(posedge clock);
        #1;
        cyc(0, 0, 0, 1, 0, ADD, NONE, 0);

        // Reset release: one IDLE cycle, then straight fetch
        cyc(1, 0, 0, 1, 0, ADD, NONE, 0);
        repeat (5) cyc(1, 0, 0, 1, 0, ADD, FET, 0);
        cyc(1, 0, 0, 1, 0, ADD, FET, 0);

        // Single-cycle branch pulse: three bubbles then fetch
        cyc(1, 1, 0, 1, 0, ADD, BRN, 0);
        cyc(1, 0, 0, 1, 0, ADD, BUB, 0);
        cyc(1, 0, 0, 1, 0, ADD, BUB, 0);
        cyc(1, 0, 0, 1, 0, ADD, FET, 0);

        // STOP, hold in HALT, resume
        cyc(1, 0, 0, 1, 0, STOP, NONE, 0);
        repeat (10) cyc(1, 0, 0, 1, 0, STOP, NONE, 1);
        cyc(1, 0, 0, 1, 1, STOP, NONE, 1);
        cyc(1, 0, 0, 1, 0, ADD, FET, 0);
        cyc(1, 0, 0, 1, 0, ADD, FET, 0);

        // Branch beats resume while halted
        cyc(1, 0, 0, 1, 0, STOP, NONE, 0);
        cyc(1, 0, 0, 1, 0, STOP, NONE, 1);
        cyc(1, 1, 0, 1, 1, STOP, BRN, 1);
        cyc(1, 0, 0, 1, 0, ADD, BUB, 0);
        cyc(1, 0, 0, 1, 0, ADD, BUB, 0);
        cyc(1, 0, 0, 1, 0, ADD, FET, 0);

        // Stall dominates a memory wait, then a plain wait bubble
        repeat (3) cyc(1, 0, 1, 0, 0, ADD, NONE, 0);
        cyc(1, 0, 0, 0, 0, ADD, BUB, 0);
        cyc(1, 0, 0, 1, 0, ADD, FET, 0);

        // Stall is ignored inside the branch shadow
        cyc(1, 1, 0, 1, 0, ADD, BRN, 0);
        cyc(1, 0, 1, 1, 0, ADD, BUB, 0);
        cyc(1, 0, 1, 1, 0, ADD, BUB, 0);
        cyc(1, 0, 0, 1, 0, ADD, FET, 0);

        // Reset in FLUSH with two bubbles pending: nothing survives
        cyc(1, 1, 0, 1, 0, ADD, BRN, 0);
        cyc(0, 0, 0, 1, 0, ADD, NONE, 0);
        cyc(1, 0, 0, 1, 0, ADD, NONE, 0);
        cyc(1, 0, 0, 1, 0, ADD, FET, 0);
        cyc(1, 0, 0, 1, 0, ADD, FET, 0);
        cyc(1, 0, 0, 1, 0, ADD, FET, 0);

        @(negedge clock);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
